// File: rtl/step_sequencer.sv
// Microcode T-state sequencer: steps 0..7 through a 3-to-8 decoder, with stall,
// early end-of-instruction, halt at instruction boundaries and a retired-instruction counter.
module step_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             stall,
  input  logic             end_step,
  input  logic             halt,
  input  logic             resume,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             g1,
  output logic             g2a,
  output logic             g2b,
  output logic [2:0]       step,
  output logic             halted,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state;
  logic   halt_pending;
  logic   boundary;

  assign {a, b, c} = step;

  always_comb begin
    boundary = end_step || (step == 3'd7);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      step         <= '0;
      g1           <= 1'b0;
      g2a          <= 1'b1;
      g2b          <= 1'b1;
      halted       <= 1'b0;
      instr_done   <= 1'b0;
      instr_count  <= '0;
      halt_pending <= 1'b0;
    end else begin
      instr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state <= RUN;
            step  <= '0;
            g1    <= 1'b1;
            g2a   <= 1'b0;
            g2b   <= 1'b0;
          end
        end
        RUN: begin
          if (stall) begin
            // stalled edge: step frozen, decoder disabled next cycle, halt still latched
            g2a <= 1'b1;
            if (halt) halt_pending <= 1'b1;
          end else begin
            g2a <= 1'b0;
            if (boundary) begin
              step        <= '0;
              instr_done  <= 1'b1;
              instr_count <= instr_count + CNT_ONE;
              if (halt_pending || halt) begin
                state        <= HALT;
                g1           <= 1'b0;
                g2a          <= 1'b1;
                g2b          <= 1'b1;
                halted       <= 1'b1;
                halt_pending <= 1'b0;
              end
            end else begin
              step <= step + 3'd1;
              if (halt) halt_pending <= 1'b1;
            end
          end
        end
        HALT: begin
          if (resume) begin
            state  <= RUN;
            step   <= '0;
            g1     <= 1'b1;
            g2a    <= 1'b0;
            g2b    <= 1'b0;
            halted <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
